// File: rtl/rgb_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_led_pkg
//  Description : Shared types and constants for the RGB LED fader:
//                default duty width, fader state encoding, channel indices
//                inside the packed {r,g,b} colour word, and a slice helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_led_pkg;

  localparam int c_DUTY_W_DEF = 8;

  // Channel position inside a packed colour word; red occupies the MSBs.
  localparam int c_CH_R = 2;
  localparam int c_CH_G = 1;
  localparam int c_CH_B = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  // LSB position of one channel inside a packed {r,g,b} word.
  function automatic int chan_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One colour channel of the fader. Holds the current and
//                target duty, computes the next current duty (jump to target
//                or one LSB toward it) and drives the registered PWM compare.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - latch i_tgt as the new target
//                i_tgt         - target duty
//                i_jump        - load current duty from target
//                i_step        - move current duty 1 LSB toward target
//                i_pwm_cnt     - shared PWM counter
//                o_done        - current duty equals target after this cycle
//                o_led         - PWM output (pwm_cnt < cur), one cycle late
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DUTY_W-1:0] i_tgt,
  input  logic              i_jump,
  input  logic              i_step,
  input  logic [DUTY_W-1:0] i_pwm_cnt,
  output logic              o_done,
  output logic              o_led
);

  logic [DUTY_W-1:0] r_cur;
  logic [DUTY_W-1:0] r_tgt;
  logic [DUTY_W-1:0] w_cur_nxt;
  logic              r_led;

  // Steps stop on the target, so the duty can never overshoot or wrap.
  always_comb begin
    w_cur_nxt = r_cur;
    if (i_jump) begin
      w_cur_nxt = r_tgt;
    end else if (i_step) begin
      if (r_cur < r_tgt) begin
        w_cur_nxt = r_cur + 1'b1;
      end else if (r_cur > r_tgt) begin
        w_cur_nxt = r_cur - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur <= '0;
      r_tgt <= '0;
      r_led <= 1'b0;
    end else begin
      if (i_load) begin
        r_tgt <= i_tgt;
      end
      r_cur <= w_cur_nxt;
      r_led <= (i_pwm_cnt < r_cur);
    end
  end

  assign o_done = (w_cur_nxt == r_tgt);
  assign o_led  = r_led;

endmodule
`default_nettype wire

// File: rtl/rgb_led_fader.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_led_fader
//  Description : Three-channel PWM LED driver with linear, glitch-free fades.
//                Duties only change at the end of a full PWM period.
//  Ports       : clk        - single clock
//                rst        - synchronous active-high reset
//                cmd_valid  - colour command present
//                cmd_ready  - command can be accepted (IDLE and not in reset)
//                cmd_rgb    - target duty {r,g,b}, red in the MSBs
//                cmd_rate   - PWM periods per 1-LSB step, 0 = jump
//                busy       - fade or jump in progress
//                redled, greenled, blueled - PWM outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_led_fader
  import rgb_led_pkg::*;
#(
  parameter int PRESCALE = 64,
  parameter int DUTY_W   = c_DUTY_W_DEF,
  parameter int RATE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3*DUTY_W-1:0] cmd_rgb,
  input  logic [RATE_W-1:0]   cmd_rate,
  output logic                busy,
  output logic                redled,
  output logic                greenled,
  output logic                blueled
);

  // A prescale of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int                 c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);

  logic [c_PRE_W-1:0] r_pre_cnt;
  logic [DUTY_W-1:0]  r_pwm_cnt;
  logic [RATE_W-1:0]  r_rate_cnt;
  logic [RATE_W-1:0]  r_rate;
  state_t             r_state;
  state_t             w_state_nxt;

  logic       w_pwm_tick;
  logic       w_period_end;
  logic       w_accept;
  logic       w_rate_hit;
  logic       w_jump;
  logic       w_step;
  logic       w_all_done;
  logic [2:0] w_done;
  logic [2:0] w_led;

  assign w_pwm_tick   = (r_pre_cnt == c_PRE_MAX);
  assign w_period_end = w_pwm_tick && (r_pwm_cnt == '1);

  assign cmd_ready  = (r_state == IDLE) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  assign busy       = (r_state == FADE);
  assign w_rate_hit = (r_rate_cnt == r_rate - 1'b1);
  assign w_all_done = &w_done;

  // Prescaler and PWM counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (w_pwm_tick) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // Command latch and rate divider; the divider only runs for stepped fades.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate     <= '0;
      r_rate_cnt <= '0;
    end else if (w_accept) begin
      r_rate     <= cmd_rate;
      r_rate_cnt <= '0;
    end else if ((r_state == FADE) && w_period_end && (r_rate != '0)) begin
      r_rate_cnt <= w_rate_hit ? '0 : r_rate_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion is judged on the post-update duties, so a command whose
  // target equals the current colour still finishes at one period end.
  always_comb begin
    w_state_nxt = r_state;
    w_jump      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = FADE;
        end
      end
      FADE: begin
        if (w_period_end) begin
          if (r_rate == '0) begin
            w_jump = 1'b1;
          end else if (w_rate_hit) begin
            w_step = 1'b1;
          end
          if (w_all_done) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam int c_LSB = chan_lsb(i, DUTY_W);
    pwm_channel #(
      .DUTY_W (DUTY_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_accept),
      .i_tgt     (cmd_rgb[c_LSB +: DUTY_W]),
      .i_jump    (w_jump),
      .i_step    (w_step),
      .i_pwm_cnt (r_pwm_cnt),
      .o_done    (w_done[i]),
      .o_led     (w_led[i])
    );
  end

  assign redled   = w_led[c_CH_R];
  assign greenled = w_led[c_CH_G];
  assign blueled  = w_led[c_CH_B];

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_fader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_led_fader
//  Description : Directed self-checking bench for rgb_led_fader with
//                PRESCALE=1, DUTY_W=4 (16-cycle PWM period).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_led_fader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [11:0] cmd_rgb = '0;
  logic [7:0]  cmd_rate = '0;
  logic        cmd_ready;
  logic        busy;
  logic        redled;
  logic        greenled;
  logic        blueled;

  int checks = 0;
  int errors = 0;

  // Independent model of the PWM counter phase (PRESCALE=1).
  logic [3:0] m_cnt;

  rgb_led_fader #(
    .PRESCALE (1),
    .DUTY_W   (4),
    .RATE_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rgb   (cmd_rgb),
    .cmd_rate  (cmd_rate),
    .busy      (busy),
    .redled    (redled),
    .greenled  (greenled),
    .blueled   (blueled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_cnt <= 4'd0;
    else     m_cnt <= m_cnt + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Present a command and hold it until accepted; n = cycles held off.
  task automatic send_cmd(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                          input logic [7:0] rate, output int n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rgb   = {r, g, b};
    cmd_rate  = rate;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready stayed %b, required 1 within 200 cycles", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Advance to the first sample following a period end (model count 0).
  task automatic align();
    int k = 0;
    @(negedge clk);
    while (m_cnt != 4'd0 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Count high samples over one full PWM period; flag any low-then-high.
  task automatic measure(output int hr, output int hg, output int hb, output int glitch);
    logic lr = 1'b0, lg = 1'b0, lb = 1'b0;
    hr = 0; hg = 0; hb = 0; glitch = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hr += int'(redled);
      hg += int'(greenled);
      hb += int'(blueled);
      if ((redled && lr) || (greenled && lg) || (blueled && lb)) glitch++;
      if (!redled)   lr = 1'b1;
      if (!greenled) lg = 1'b1;
      if (!blueled)  lb = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n, hr, hg, hb;
    send_cmd(4'd15, 4'd15, 4'd15, 8'd0, n);
    align();
    repeat (3) @(negedge clk);
    checks++;
    if ({redled, greenled, blueled} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_leds: got %b, required 111", {redled, greenled, blueled});
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({redled, greenled, blueled, busy, cmd_ready} !== 5'b0) begin
        errors++;
        $display("FAIL in_reset_%0d: leds/busy/ready %b, required 00000", i,
                 {redled, greenled, blueled, busy, cmd_ready});
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: ready=%b busy=%b, required ready=1 busy=0", cmd_ready, busy);
    end
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      hr += int'(redled);
      hg += int'(greenled);
      hb += int'(blueled);
    end
    checks++;
    if (hr != 0 || hg != 0 || hb != 0) begin
      errors++;
      $display("FAIL post_reset_dark: high counts r=%0d g=%0d b=%0d, required 0", hr, hg, hb);
    end
  endtask

  task automatic test_fade_up();
    int n, hr, hg, hb, gl;
    int exp_r[8] = '{0, 1, 1, 2, 2, 3, 3, 4};
    logic exp_busy;
    send_cmd(4'd4, 4'd0, 4'd0, 8'd2, n);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fade_up_start: busy=%b ready=%b, required busy=1 ready=0", busy, cmd_ready);
    end
    align();
    for (int j = 0; j < 8; j++) begin
      measure(hr, hg, hb, gl);
      exp_busy = (j < 6);
      checks++;
      if (hr != exp_r[j] || hg != 0 || hb != 0 || gl != 0) begin
        errors++;
        $display("FAIL fade_up_p%0d: r=%0d g=%0d b=%0d glitch=%0d, required r=%0d g=0 b=0 glitch=0",
                 j, hr, hg, hb, gl, exp_r[j]);
      end
      checks++;
      if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
        errors++;
        $display("FAIL fade_up_busy_p%0d: busy=%b ready=%b, required busy=%b", j, busy, cmd_ready, exp_busy);
      end
    end
  endtask

  task automatic test_fade_mixed();
    int n, hr, hg, hb, gl;
    int exp_r[4] = '{3, 2, 1, 0};
    int exp_g[4] = '{1, 2, 3, 3};
    logic exp_busy;
    send_cmd(4'd4, 4'd0, 4'd9, 8'd0, n);
    align();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mixed_preload_busy: busy=%b, required 0", busy);
    end
    send_cmd(4'd0, 4'd3, 4'd9, 8'd1, n);
    align();
    for (int j = 0; j < 4; j++) begin
      measure(hr, hg, hb, gl);
      exp_busy = (j < 2);
      checks++;
      if (hr != exp_r[j] || hg != exp_g[j] || hb != 9 || gl != 0) begin
        errors++;
        $display("FAIL mixed_p%0d: r=%0d g=%0d b=%0d glitch=%0d, required r=%0d g=%0d b=9 glitch=0",
                 j, hr, hg, hb, gl, exp_r[j], exp_g[j]);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL mixed_busy_p%0d: busy=%b, required %b", j, busy, exp_busy);
      end
    end
  endtask

  task automatic test_jump();
    int n, hr, hg, hb, gl;
    send_cmd(4'd8, 4'd0, 4'd15, 8'd0, n);
    checks++;
    if (n != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL jump_accept: wait=%0d busy=%b, required wait=0 busy=1", n, busy);
    end
    align();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL jump_done: busy=%b ready=%b, required busy=0 ready=1", busy, cmd_ready);
    end
    for (int j = 0; j < 2; j++) begin
      measure(hr, hg, hb, gl);
      checks++;
      if (hr != 8 || hg != 0 || hb != 15 || gl != 0) begin
        errors++;
        $display("FAIL jump_p%0d: r=%0d g=%0d b=%0d glitch=%0d, required r=8 g=0 b=15 glitch=0",
                 j, hr, hg, hb, gl);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, n2, hr, hg, hb, gl;
    send_cmd(4'd8, 4'd1, 4'd15, 8'd1, n);
    send_cmd(4'd8, 4'd1, 4'd14, 8'd0, n2);
    checks++;
    if (n2 < 1 || n2 > 17) begin
      errors++;
      $display("FAIL b2b_holdoff: held-off cycles=%0d, required 1..17", n2);
    end
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b ready=%b, required busy=1 ready=0", busy, cmd_ready);
    end
    align();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: busy=%b, required 0", busy);
    end
    measure(hr, hg, hb, gl);
    checks++;
    if (hr != 8 || hg != 1 || hb != 14 || gl != 0) begin
      errors++;
      $display("FAIL b2b_duty: r=%0d g=%0d b=%0d glitch=%0d, required r=8 g=1 b=14 glitch=0",
               hr, hg, hb, gl);
    end
  endtask

  task automatic test_reset_mid_fade();
    int n, hr, hg, hb, gl;
    int exp_r[4] = '{0, 1, 1, 2};
    send_cmd(4'd0, 4'd0, 4'd0, 8'd0, n);
    align();
    send_cmd(4'd4, 4'd0, 4'd0, 8'd2, n);
    align();
    for (int j = 0; j < 4; j++) begin
      measure(hr, hg, hb, gl);
      checks++;
      if (hr != exp_r[j] || hg != 0 || hb != 0) begin
        errors++;
        $display("FAIL midrst_fade_p%0d: r=%0d g=%0d b=%0d, required r=%0d g=0 b=0",
                 j, hr, hg, hb, exp_r[j]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || {redled, greenled, blueled} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_state: ready=%b busy=%b leds=%b, required ready=1 busy=0 leds=000",
               cmd_ready, busy, {redled, greenled, blueled});
    end
    align();
    for (int j = 0; j < 2; j++) begin
      measure(hr, hg, hb, gl);
      checks++;
      if (hr != 0 || hg != 0 || hb != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_dark_p%0d: r=%0d g=%0d b=%0d busy=%b, required all 0",
                 j, hr, hg, hb, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fade_up();
    test_fade_mixed();
    test_jump();
    test_back_to_back();
    test_reset_mid_fade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
